// File: rtl/song_sequencer_pkg.sv
// Shared types and constants for the song sequencer: FSM states, song entry
// field positions, end-marker/silence values and the tick counter width helper.
package song_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_ROM,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } state_e;

    localparam int NOTE_MSB = 15;
    localparam int NOTE_LSB = 6;
    localparam int DUR_MSB  = 5;
    localparam int DUR_LSB  = 0;

    localparam int NOTE_W = NOTE_MSB - NOTE_LSB + 1;
    localparam int DUR_W  = DUR_MSB - DUR_LSB + 1;

    localparam logic [DUR_W-1:0]  END_DUR = '0;
    localparam logic [NOTE_W-1:0] SILENCE = '0;

    // Width able to hold 0..max(a,b)-1, never narrower than one bit.
    function automatic int tick_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Control, song-memory and playback signals of the song sequencer. The
// sequencer is the slave; the controller/memory/playback side is the master.
interface song_sequencer_if
    import song_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8
) ();

    logic              start;
    logic              stop;
    logic              read_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [NOTE_W-1:0] data_out;
    logic              output_ready;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, read_en, rom_data,
        input  rom_addr, data_out, output_ready, busy, done
    );

    modport slave (
        input  start, stop, read_en, rom_data,
        output rom_addr, data_out, output_ready, busy, done
    );

endinterface

// File: rtl/song_sequencer_unit_ticker.sv
// Modulo counter with enable and synchronous clear; wrap_o pulses for the
// enabled cycle in which the count equals last_i, and the count returns to 0.
module unit_ticker #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] last_i,
    output logic             wrap_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        wrap_o  = en_i && !clr_i && (count_q == last_i);
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = wrap_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Beat-paced song sequencer: walks a registered song memory, presents each note
// word for duration*TICKS_PER_UNIT enabled cycles, then a silent gap.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int TICKS_PER_UNIT = 12_500_000,
    parameter int GAP_TICKS      = 1_250_000,
    parameter bit LOOP           = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    song_sequencer_if.slave bus
);

    localparam int TICK_W = tick_width(TICKS_PER_UNIT, GAP_TICKS);
    localparam logic [TICK_W-1:0] PLAY_LAST = TICK_W'(TICKS_PER_UNIT - 1);
    localparam logic [TICK_W-1:0] GAP_LAST  =
        (GAP_TICKS > 0) ? TICK_W'(GAP_TICKS - 1) : '0;
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [DUR_W-1:0]  unit_q, unit_d;
    logic              played_q, played_d;

    logic              tick_clr;
    logic [TICK_W-1:0] tick_last;
    logic              tick_wrap;

    logic [DUR_W-1:0]  entry_dur;
    logic [NOTE_W-1:0] entry_note;
    logic              at_last;
    state_e            adv_state;
    logic [ADDR_W-1:0] adv_addr;

    assign entry_dur  = bus.rom_data[DUR_MSB:DUR_LSB];
    assign entry_note = bus.rom_data[NOTE_MSB:NOTE_LSB];

    // The last address acts as an implicit end marker.
    assign at_last   = (addr_q == ADDR_LAST);
    assign adv_state = at_last ? ST_DONE : ST_FETCH;
    assign adv_addr  = at_last ? addr_q : addr_q + 1'b1;

    // One ticker serves both the note and the gap; it idles cleared elsewhere.
    assign tick_clr  = (state_q != ST_PLAY) && (state_q != ST_GAP);
    assign tick_last = (state_q == ST_GAP) ? GAP_LAST : PLAY_LAST;

    unit_ticker #(
        .WIDTH (TICK_W)
    ) u_ticker (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (tick_clr),
        .en_i   (bus.read_en),
        .last_i (tick_last),
        .wrap_o (tick_wrap)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        note_d   = note_q;
        unit_d   = unit_q;
        played_d = played_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    addr_d   = '0;
                    played_d = 1'b0;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT_ROM;
            end
            ST_WAIT_ROM: begin
                if (entry_dur == END_DUR) begin
                    state_d = ST_DONE;
                end else begin
                    note_d   = entry_note;
                    unit_d   = entry_dur;
                    played_d = 1'b1;
                    state_d  = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (tick_wrap) begin
                    unit_d = unit_q - 1'b1;
                    if (unit_q == DUR_W'(1)) begin
                        note_d = SILENCE;
                        if (GAP_TICKS > 0) begin
                            state_d = ST_GAP;
                        end else begin
                            state_d = adv_state;
                            addr_d  = adv_addr;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (tick_wrap) begin
                    state_d = adv_state;
                    addr_d  = adv_addr;
                end
            end
            ST_DONE: begin
                // Looping needs at least one real note, otherwise it would spin.
                if (LOOP && played_q) begin
                    addr_d  = '0;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.stop && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            addr_d   = '0;
            note_d   = SILENCE;
            unit_d   = '0;
            played_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            note_q   <= SILENCE;
            unit_q   <= '0;
            played_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            note_q   <= note_d;
            unit_q   <= unit_d;
            played_q <= played_d;
        end
    end

    assign bus.rom_addr     = addr_q;
    assign bus.data_out     = (state_q == ST_PLAY) ? note_q : SILENCE;
    assign bus.output_ready = (state_q == ST_PLAY) || (state_q == ST_GAP);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.done         = (state_q == ST_DONE) && !(LOOP && played_q);

endmodule
